seg_scan_display: RTL and testbench

Parametrised multiplexed 7-segment driver for the vending-machine front panel. It accepts CH binary values (stock quantity, max-add, sales count, …), converts each to decimal with a sequential double-dabble engine, and time-multiplexes the result onto one shared segment bus with a one-hot digit enable. It sits between the product/sales control logic and the board's seven-segment pins.

---
 rtl/seg_scan_display.sv | 201 ++++++++++++++++++++
 tb/tb_seg_scan_display.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed 7-segment driver for the vending-machine panel.
// Each channel is converted to BCD by a sequential double-dabble engine. The
// digits are then scanned onto one shared segment bus with a one-hot digit enable.
// Optional feature: define SEG_BLINK_EN to add per-channel blinking via blink_mask.
// DIGS must not exceed 5 (VAL_W <= 14 yields at most five decimal digits).
module seg_scan_display #(
    parameter int CH        = 2,
    parameter int DIGS      = 2,
    parameter int VAL_W     = 7,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000,
    parameter int LZ_BLANK  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*VAL_W-1:0]   val,
    input  logic                  seg_en,
    input  logic [CH-1:0]         blink_mask,
    output logic [7:0]            seg,
    output logic [7:0]            dig,
    output logic [CH-1:0]         ovf,
    output logic                  conv_busy
);

    localparam int POS_N = CH * DIGS;
    localparam int POS_W = (POS_N > 1) ? $clog2(POS_N) : 1;
    localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
    localparam int BIT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;
    localparam int PS_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BCD_W = 20;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE} state_t;

    state_t                       r_state, w_state_nxt;
    logic [VAL_W-1:0]             r_bin;
    logic [BCD_W-1:0]             r_bcd, w_adj;
    logic [BIT_W-1:0]             r_bit;
    logic [CH_W-1:0]              r_ch_ptr;
    logic [CH-1:0][DIGS*4-1:0]    r_disp;
    logic [CH-1:0]                r_ovf;
    logic [CH-1:0][VAL_W-1:0]     w_vals;
    logic [PS_W-1:0]              r_presc;
    logic [POS_W-1:0]             r_pos, w_pos_nxt;
    logic                         w_tick;
    logic [7:0]                   r_seg, r_dig;
    logic [7:0]                   w_code [POS_N];
    logic                         w_blank_blink;

    assign w_vals    = val;
    assign conv_busy = (r_state != S_IDLE);
    assign ovf       = r_ovf;
    assign seg       = r_seg;
    assign dig       = r_dig;

    function automatic logic [7:0] f_seg7(input logic [3:0] n);
        case (n)
            4'd0: f_seg7 = 8'h3F;
            4'd1: f_seg7 = 8'h06;
            4'd2: f_seg7 = 8'h5B;
            4'd3: f_seg7 = 8'h4F;
            4'd4: f_seg7 = 8'h66;
            4'd5: f_seg7 = 8'h6D;
            4'd6: f_seg7 = 8'h7D;
            4'd7: f_seg7 = 8'h27;
            4'd8: f_seg7 = 8'h7F;
            4'd9: f_seg7 = 8'h67;
            default: f_seg7 = 8'h00;
        endcase
    endfunction

    // Converter state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Converter next state: runs continuously, one channel per pass
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (r_bit == BIT_W'(VAL_W - 1)) w_state_nxt = S_STORE;
            S_STORE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every nibble that is 5 or more
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_W / 4; i++)
            if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end

    // Converter datapath: capture, shift, then commit digits and overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin    <= '0;
            r_bcd    <= '0;
            r_bit    <= '0;
            r_ch_ptr <= '0;
            r_disp   <= '0;
            r_ovf    <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_bin <= w_vals[r_ch_ptr];
                    r_bcd <= '0;
                    r_bit <= '0;
                end
                S_SHIFT: begin
                    r_bcd <= (w_adj << 1) | BCD_W'(r_bin[VAL_W-1]);
                    r_bin <= r_bin << 1;
                    r_bit <= r_bit + 1'b1;
                end
                S_STORE: begin
                    r_disp[r_ch_ptr] <= r_bcd[DIGS*4-1:0];
                    r_ovf[r_ch_ptr]  <= |(r_bcd >> (DIGS * 4));
                    r_ch_ptr         <= (r_ch_ptr == CH_W'(CH - 1)) ? '0 : r_ch_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BL_W-1:0] r_blink_cnt;
    logic            r_blink_phase;

    // Free-running blink timebase; phase flips every BLINK_DIV cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BL_W'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end
    assign w_blank_blink = r_blink_phase;
`else
    logic w_unused_blink;
    assign w_unused_blink = &{1'b0, blink_mask, BLINK_DIV[0]};
    assign w_blank_blink  = 1'b0;
`endif

    // Segment code for every scan position; digit 0 is the most significant
    always_comb begin
        logic       w_zr;
        logic [3:0] w_nib;
        for (int c = 0; c < CH; c++) begin
            w_zr = 1'b1;
            for (int d = 0; d < DIGS; d++) begin
                w_nib = r_disp[c][(DIGS-1-d)*4 +: 4];
                w_zr  = w_zr && (w_nib == 4'd0);
                if (r_ovf[c])
                    w_code[c*DIGS+d] = 8'h40;
                else if ((LZ_BLANK != 0) && w_zr && (d != DIGS - 1))
                    w_code[c*DIGS+d] = 8'h00;
                else
                    w_code[c*DIGS+d] = f_seg7(w_nib);
`ifdef SEG_BLINK_EN
                if (w_blank_blink && blink_mask[c]) w_code[c*DIGS+d] = 8'h00;
`else
                if (w_blank_blink) w_code[c*DIGS+d] = 8'h00;
`endif
            end
        end
    end

    assign w_tick    = (r_presc == PS_W'(SCAN_DIV - 1));
    assign w_pos_nxt = !w_tick ? r_pos :
                       (r_pos == POS_W'(POS_N - 1)) ? '0 : r_pos + 1'b1;

    // Scan prescaler and position counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_pos   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_pos   <= w_pos_nxt;
        end
    end

    // Registered outputs: follow the next position so seg/dig move with pos
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_seg <= 8'h00;
            r_dig <= 8'h00;
        end else begin
            r_seg <= w_code[w_pos_nxt];
            r_dig <= seg_en ? (8'd1 << w_pos_nxt) : 8'h00;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: two instances (LZ_BLANK=0 and LZ_BLANK=1) share
// stimulus; SCAN_DIV=4, BLINK_DIV=16. Blink checks adapt to SEG_BLINK_EN.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] val;
    logic        seg_en;
    logic [1:0]  blink_mask;
    logic [7:0]  seg0, dig0, seg1, dig1;
    logic [1:0]  ovf0, ovf1;
    logic        busy0, busy1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seg_scan_display #(.CH(2), .DIGS(2), .VAL_W(7), .SCAN_DIV(4), .BLINK_DIV(16), .LZ_BLANK(0)) u_dut (
        .clk(clk), .rst(rst), .val(val), .seg_en(seg_en), .blink_mask(blink_mask),
        .seg(seg0), .dig(dig0), .ovf(ovf0), .conv_busy(busy0)
    );

    seg_scan_display #(.CH(2), .DIGS(2), .VAL_W(7), .SCAN_DIV(4), .BLINK_DIV(16), .LZ_BLANK(1)) u_dut_lz (
        .clk(clk), .rst(rst), .val(val), .seg_en(seg_en), .blink_mask(blink_mask),
        .seg(seg1), .dig(dig1), .ovf(ovf1), .conv_busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) until the scan reaches position p
    task automatic at_pos(input int p);
        logic [7:0] want;
        want = 8'(1 << p);
        for (int i = 0; i < 40 && dig0 !== want; i++) @(negedge clk);
        chk("pos_dig", dig0, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int off_n, on_n, bad_n;
        rst = 1'b0; val = '0; seg_en = 1'b1; blink_mask = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg0, 8'h00);
        chk("rst_dig", dig0, 8'h00);
        chk("rst_ovf", ovf0, 2'b00);
        chk("rst_busy", busy0, 1'b0);
        rst = 1'b1;

        // scan sequence after release
        @(negedge clk);
        chk("scan_k1", dig0, 8'h01);
        chk("seg_zero_p0", seg0, 8'h3F);
        chk("busy_run", busy0, 1'b1);
        chk("lz_zero_p0", seg1, 8'h00);
        repeat (3) @(negedge clk);
        chk("scan_k4", dig0, 8'h02);
        chk("seg_zero_p1", seg0, 8'h3F);
        chk("lz_zero_p1", seg1, 8'h3F);
        repeat (4) @(negedge clk);
        chk("scan_k8", dig0, 8'h04);
        chk("seg_zero_p2", seg0, 8'h3F);
        repeat (4) @(negedge clk);
        chk("scan_k12", dig0, 8'h08);
        repeat (4) @(negedge clk);
        chk("scan_k16", dig0, 8'h01);

        // 42 / 09
        val = {7'd9, 7'd42};
        repeat (40) @(negedge clk);
        at_pos(0); chk("v42_p0", seg0, 8'h66); chk("lz42_p0", seg1, 8'h66);
        at_pos(1); chk("v42_p1", seg0, 8'h5B);
        at_pos(2); chk("v9_p2", seg0, 8'h3F);  chk("lz9_p2", seg1, 8'h00);
        at_pos(3); chk("v9_p3", seg0, 8'h67);  chk("lz9_p3", seg1, 8'h67);
        chk("v42_ovf", ovf0, 2'b00);

        // overflow and recovery
        val = {7'd9, 7'd127};
        repeat (40) @(negedge clk);
        at_pos(0); chk("ovf_p0", seg0, 8'h40);
        at_pos(1); chk("ovf_p1", seg0, 8'h40);
        chk("ovf_set", ovf0, 2'b01);
        val = {7'd9, 7'd5};
        repeat (40) @(negedge clk);
        chk("ovf_clr", ovf0, 2'b00);
        at_pos(0); chk("v5_p0", seg0, 8'h3F); chk("lz5_p0", seg1, 8'h00);
        at_pos(1); chk("v5_p1", seg0, 8'h6D); chk("lz5_p1", seg1, 8'h6D);

        // leading-zero blanking
        val = {7'd9, 7'd7};
        repeat (40) @(negedge clk);
        at_pos(0); chk("lz7_p0", seg1, 8'h00);
        at_pos(1); chk("lz7_p1", seg1, 8'h27); chk("v7_p1", seg0, 8'h27);
        val = {7'd9, 7'd0};
        repeat (40) @(negedge clk);
        at_pos(1); chk("lz0_p1", seg1, 8'h3F);

        // reset in the middle of a shift
        val = {7'd9, 7'd127};
        repeat (40) @(negedge clk);
        chk("pre_rst_ovf", ovf0, 2'b01);
        for (int i = 0; i < 20 && busy0 !== 1'b0; i++) @(negedge clk);
        for (int i = 0; i < 20 && busy0 !== 1'b1; i++) @(negedge clk);
        chk("busy_rise", busy0, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_seg", seg0, 8'h00);
        chk("mid_rst_dig", dig0, 8'h00);
        chk("mid_rst_ovf", ovf0, 2'b00);
        chk("mid_rst_busy", busy0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        repeat (9) @(negedge clk);
        chk("post_rst_k9_ovf", ovf0, 2'b00);
        @(negedge clk);
        chk("post_rst_k10_ovf", ovf0, 2'b01);
        chk("post_rst_k10_dig", dig0, 8'h04);
        at_pos(0); chk("post_rst_p0", seg0, 8'h40);

        // blink on channel 1
        blink_mask = 2'b10;
        off_n = 0; on_n = 0; bad_n = 0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (dig0 == 8'h04 || dig0 == 8'h08) begin
                if (seg0 == 8'h00) off_n++;
                else begin
                    on_n++;
                    if (seg0 != ((dig0 == 8'h04) ? 8'h3F : 8'h67)) bad_n++;
                end
            end else if (seg0 != 8'h40) bad_n++;
        end
        chk("blink_bad", bad_n, 0);
        chk("blink_on_seen", (on_n > 0), 1);
`ifdef SEG_BLINK_EN
        chk("blink_off_seen", (off_n > 0), 1);
`else
        chk("blink_off_none", off_n, 0);
`endif

        // digit enable gating
        seg_en = 1'b0;
        bad_n = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (dig0 != 8'h00) bad_n++;
        end
        chk("dig_off", bad_n, 0);
        chk("dig_off_now", dig0, 8'h00);
        seg_en = 1'b1;
        @(negedge clk);
        chk("dig_on_next", (dig0 != 8'h00), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
